// File: rtl/run_mon_pkg.sv
// run_mon_pkg: shared state encoding and instruction constants for the run monitor
package run_mon_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
  localparam logic [31:0] INSTR_ECALL  = 32'h00000073;
  localparam logic [31:0] INSTR_EBREAK = 32'h00100073;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: clearable up-counter that sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);
  logic [CNT_W-1:0] q_q, q_d;
  always_comb q_d = clr ? '0 : (inc && !(&q_q)) ? q_q + CNT_W'(1) : q_q;
  always_ff @(posedge clk) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end
  assign q = q_q;
endmodule

// File: rtl/run_perf_monitor.sv
// run_perf_monitor: run-control FSM with cycle/retire/event counters,
// cycle limit and retire watchdog for the sequential core
module run_perf_monitor
  import run_mon_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter int              NUM_EVT      = 4,
  parameter int              CNT_W        = 32,
  parameter int              MAX_CYCLES   = 1000,
  parameter int              WDOG_CYCLES  = 64,
  parameter int              DRAIN_CYCLES = 2,
  parameter logic [XLEN-1:0] HALT_INSTR   = XLEN'(INSTR_ECALL)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     instr_valid,
  input  logic [XLEN-1:0]          instr,
  input  logic [XLEN-1:0]          pc,
  input  logic [NUM_EVT-1:0]       evt_in,
  output logic                     busy,
  output logic                     done,
  output logic                     halted,
  output logic                     timeout,
  output logic                     wdog_trip,
  output logic [XLEN-1:0]          halt_pc,
  output logic [CNT_W-1:0]         cycle_cnt,
  output logic [CNT_W-1:0]         retire_cnt,
  output logic [NUM_EVT*CNT_W-1:0] evt_cnt
);
  localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_CYCLES);
  localparam logic [CNT_W-1:0] WDOG_C  = CNT_W'(WDOG_CYCLES);
  localparam logic [CNT_W-1:0] DRAIN_C = CNT_W'(DRAIN_CYCLES);

  if (CNT_W < 31 && MAX_CYCLES >= (1 << CNT_W)) begin : g_bad_max
    $error("MAX_CYCLES does not fit in CNT_W bits");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wdog_q, wdog_d, drain_q, drain_d;
  logic [XLEN-1:0]  halt_pc_q, halt_pc_d;
  logic             halted_q, halted_d, timeout_q, timeout_d, wdog_trip_q, wdog_trip_d;
  logic             go, run, drn, halt_hit, lim_hit, wd_hit, drain_last;
  logic [CNT_W-1:0] wdog_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    go         = start && (state_q == IDLE || state_q == DONE);
    run        = state_q == RUN;
    drn        = state_q == DRAIN;
    wdog_nxt   = wdog_q + CNT_W'(1);
    halt_hit   = run && instr_valid && instr == HALT_INSTR;
    lim_hit    = run && MAX_CYCLES != 0 && cycle_cnt + CNT_W'(1) == MAX_C;
    wd_hit     = run && WDOG_CYCLES != 0 && !instr_valid && wdog_nxt == WDOG_C;
    drain_last = drn && drain_q == DRAIN_C;
    state_d    = go ? RUN :
                 halt_hit ? DRAIN :
                 (lim_hit || wd_hit || drain_last) ? DONE : state_q;
  end

  always_comb begin
    busy = state_q == RUN || state_q == DRAIN;
    done = state_q == DONE;
  end

  // Halt outranks both timeouts, and the cycle limit outranks the watchdog.
  always_comb begin
    halted_d    = go ? 1'b0 : drain_last ? 1'b1 : halted_q;
    timeout_d   = go ? 1'b0 : (!halt_hit && (lim_hit || wd_hit)) ? 1'b1 : timeout_q;
    wdog_trip_d = go ? 1'b0 : (!halt_hit && !lim_hit && wd_hit) ? 1'b1 : wdog_trip_q;
    halt_pc_d   = go ? '0 : halt_hit ? pc : halt_pc_q;
    wdog_d      = go ? '0 : run ? (instr_valid ? '0 : wdog_nxt) : wdog_q;
    drain_d     = (go || halt_hit) ? '0 : drn ? drain_q + CNT_W'(1) : drain_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      halted_q    <= 1'b0;
      timeout_q   <= 1'b0;
      wdog_trip_q <= 1'b0;
      halt_pc_q   <= '0;
      wdog_q      <= '0;
      drain_q     <= '0;
    end else begin
      halted_q    <= halted_d;
      timeout_q   <= timeout_d;
      wdog_trip_q <= wdog_trip_d;
      halt_pc_q   <= halt_pc_d;
      wdog_q      <= wdog_d;
      drain_q     <= drain_d;
    end
  end

  assign halted    = halted_q;
  assign timeout   = timeout_q;
  assign wdog_trip = wdog_trip_q;
  assign halt_pc   = halt_pc_q;

  sat_counter #(.CNT_W(CNT_W)) u_cycle (
    .clk(clk), .rst_n(rst_n), .clr(go), .inc(run || drn), .q(cycle_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_retire (
    .clk(clk), .rst_n(rst_n), .clr(go), .inc(run && instr_valid), .q(retire_cnt)
  );

  for (genvar i = 0; i < NUM_EVT; i++) begin : g_evt
    sat_counter #(.CNT_W(CNT_W)) u_evt (
      .clk(clk), .rst_n(rst_n), .clr(go), .inc((run || drn) && evt_in[i]),
      .q(evt_cnt[i*CNT_W +: CNT_W])
    );
  end
endmodule

// File: tb/tb_run_perf_monitor.sv
// tb_run_perf_monitor: scoreboarded directed bench; main instance uses a 20-cycle
// limit and 5-cycle watchdog, a second 4-bit instance exercises saturation
module tb_run_perf_monitor;
  import run_mon_pkg::*;

  localparam logic [31:0] NOP = 32'h00000013;

  typedef struct {
    string        tag;
    logic         h, t, w;
    logic [31:0]  pc, cyc, ret;
    logic [127:0] evt;
  } exp_t;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start_a = 0, valid_a = 0;
  logic [31:0]   instr_a = 0, pc_a = 0;
  logic [3:0]    evt_in_a = 0;
  logic          busy_a, done_a, halted_a, timeout_a, wdog_a;
  logic [31:0]   halt_pc_a, cycle_a, retire_a;
  logic [127:0]  evt_a;

  logic          start_b = 0, valid_b = 0;
  logic [31:0]   instr_b = 0, pc_b = 0;
  logic [1:0]    evt_in_b = 0;
  logic          busy_b, done_b, halted_b, timeout_b, wdog_b;
  logic [31:0]   halt_pc_b;
  logic [3:0]    cycle_b, retire_b;
  logic [7:0]    evt_b;

  run_perf_monitor #(
    .XLEN(32), .NUM_EVT(4), .CNT_W(32), .MAX_CYCLES(20), .WDOG_CYCLES(5), .DRAIN_CYCLES(2)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start_a), .instr_valid(valid_a), .instr(instr_a),
    .pc(pc_a), .evt_in(evt_in_a), .busy(busy_a), .done(done_a), .halted(halted_a),
    .timeout(timeout_a), .wdog_trip(wdog_a), .halt_pc(halt_pc_a), .cycle_cnt(cycle_a),
    .retire_cnt(retire_a), .evt_cnt(evt_a)
  );

  run_perf_monitor #(
    .XLEN(32), .NUM_EVT(2), .CNT_W(4), .MAX_CYCLES(0), .WDOG_CYCLES(0), .DRAIN_CYCLES(0)
  ) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start_b), .instr_valid(valid_b), .instr(instr_b),
    .pc(pc_b), .evt_in(evt_in_b), .busy(busy_b), .done(done_b), .halted(halted_b),
    .timeout(timeout_b), .wdog_trip(wdog_b), .halt_pc(halt_pc_b), .cycle_cnt(cycle_b),
    .retire_cnt(retire_b), .evt_cnt(evt_b)
  );

  int   passed = 0, total = 0;
  exp_t q_a[$], q_b[$];
  logic prev_a = 0, prev_b = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic exp_t mk(input string tag, input logic h, input logic t, input logic w,
                              input logic [31:0] pc, input logic [31:0] cyc,
                              input logic [31:0] ret, input logic [127:0] evt);
    exp_t e;
    e.tag = tag; e.h = h; e.t = t; e.w = w; e.pc = pc; e.cyc = cyc; e.ret = ret; e.evt = evt;
    return e;
  endfunction

  task automatic score(input exp_t e, input logic h, input logic t, input logic w,
                       input logic [31:0] pc, input logic [31:0] cyc, input logic [31:0] ret,
                       input logic [127:0] evt);
    check({e.tag, " halted"}, h, e.h);
    check({e.tag, " timeout"}, t, e.t);
    check({e.tag, " wdog_trip"}, w, e.w);
    check({e.tag, " halt_pc"}, pc, e.pc);
    check({e.tag, " cycle_cnt"}, cyc, e.cyc);
    check({e.tag, " retire_cnt"}, ret, e.ret);
    check({e.tag, " evt_cnt"}, evt, e.evt);
  endtask

  always @(negedge clk) begin
    if (done_a && !prev_a) begin
      if (q_a.size() == 0) check("unexpected done on main", 1, 0);
      else score(q_a.pop_front(), halted_a, timeout_a, wdog_a, halt_pc_a, cycle_a, retire_a, evt_a);
    end
    prev_a = done_a;
  end

  always @(negedge clk) begin
    if (done_b && !prev_b) begin
      if (q_b.size() == 0) check("unexpected done on sat", 1, 0);
      else score(q_b.pop_front(), halted_b, timeout_b, wdog_b, halt_pc_b,
                 32'(cycle_b), 32'(retire_b), 128'(evt_b));
    end
    prev_b = done_b;
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic go_a();
    step(); start_a = 1; step(); start_a = 0;
  endtask

  task automatic go_b();
    step(); start_b = 1; step(); start_b = 0;
  endtask

  task automatic wait_done(input string name, input bit which_b);
    int n = 0;
    while (!(which_b ? done_b : done_a) && n < 200) begin @(negedge clk); n++; end
    check({name, " reached done"}, which_b ? done_b : done_a, 1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    check("reset busy", busy_a, 0);
    check("reset done", done_a, 0);
    check("reset cycle_cnt", cycle_a, 0);
    check("reset evt_cnt", evt_a, 0);

    // 11 retires (ECALL at 0x28) plus 3 drain cycles; start mid-run is ignored
    q_a.push_back(mk("halt_run", 1, 0, 0, 32'h28, 14, 11, {32'd0, 32'd4, 32'd0, 32'd11}));
    go_a();
    for (int k = 0; k < 10; k++) begin
      valid_a = 1; instr_a = NOP; pc_a = 32'(k * 4);
      evt_in_a = k < 4 ? 4'b0101 : 4'b0001; start_a = (k == 5);
      step();
    end
    start_a = 0; instr_a = INSTR_ECALL; pc_a = 32'h28;
    step();
    valid_a = 0; evt_in_a = 0; instr_a = 0;
    wait_done("halt_run", 0);

    q_a.push_back(mk("limit_run", 0, 1, 0, 0, 20, 20, {32'd20, 32'd0, 32'd0, 32'd0}));
    go_a();
    valid_a = 1; instr_a = NOP; evt_in_a = 4'b1000;
    wait_done("limit_run", 0);
    repeat (3) @(negedge clk);
    check("done holds cycle_cnt", cycle_a, 20);
    check("done holds evt_cnt[3]", evt_a[127:96], 20);
    valid_a = 0; evt_in_a = 0;

    q_a.push_back(mk("wdog_run", 0, 1, 1, 0, 8, 3, 0));
    go_a();
    valid_a = 1; instr_a = NOP;
    repeat (3) step();
    valid_a = 0;
    wait_done("wdog_run", 0);

    q_b.push_back(mk("sat_run", 1, 0, 0, 32'h40, 15, 1, 128'hF0));
    go_b();
    evt_in_b = 2'b10;
    repeat (30) step();
    evt_in_b = 0; valid_b = 1; instr_b = INSTR_ECALL; pc_b = 32'h40;
    step();
    valid_b = 0;
    wait_done("sat_run", 1);

    // halt lands on the same edge the 20-cycle limit would fire
    q_a.push_back(mk("halt_vs_limit", 1, 0, 0, 32'h4C, 23, 20, 0));
    go_a();
    for (int k = 0; k < 20; k++) begin
      valid_a = 1; instr_a = k == 19 ? INSTR_ECALL : NOP; pc_a = 32'(k * 4);
      step();
    end
    valid_a = 0;
    wait_done("halt_vs_limit", 0);
    go_a();
    @(negedge clk);
    check("restart busy", busy_a, 1);
    check("restart done", done_a, 0);
    check("restart halted", halted_a, 0);
    check("restart cycle_cnt", cycle_a, 0);
    check("restart retire_cnt", retire_a, 0);
    check("restart halt_pc", halt_pc_a, 0);

    valid_a = 1; instr_a = NOP; evt_in_a = 4'b0010;
    repeat (3) step();
    rst_n = 0;
    step();
    rst_n = 1; valid_a = 0; evt_in_a = 0;
    @(negedge clk);
    check("midrun reset flags", {busy_a, done_a, halted_a, timeout_a, wdog_a}, 0);
    check("midrun reset counters", {cycle_a, retire_a, halt_pc_a}, 0);
    check("midrun reset evt_cnt", evt_a, 0);

    // EBREAK must not stop the run; only ECALL does
    q_a.push_back(mk("after_reset", 1, 0, 0, 32'h108, 6, 3, 0));
    go_a();
    valid_a = 1; instr_a = NOP; pc_a = 32'h100; step();
    instr_a = INSTR_EBREAK; pc_a = 32'h104; step();
    instr_a = INSTR_ECALL; pc_a = 32'h108; step();
    valid_a = 0;
    wait_done("after_reset", 0);

    repeat (2) @(negedge clk);
    check("main scoreboard drained", q_a.size(), 0);
    check("sat scoreboard drained", q_b.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench still running at %0t", $time);
    $fatal(1, "bench did not terminate");
  end
endmodule
